// File: rtl/snd_dma_pkg.sv
// Shared types and register-select codes for the DMA-sound address sequencer.
package snd_dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFetch,
        StWait
    } state_e;

    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_START = 2'd1;
    localparam logic [1:0] SEL_END   = 2'd2;

endpackage

// File: rtl/snd_fifo.sv
// Synchronous word FIFO; free_o accounts for slots already promised to in-flight fetches.
module snd_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PW = $clog2(Depth),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [15:0]   data_i,
    input  logic          pop_i,
    input  logic [CW-1:0] rsv_i,
    output logic [15:0]   data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic          free_o
);

    logic [15:0]   mem_q [Depth];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   hold_q;
    logic          push_ok, pop_ok;
    logic [CW:0]   used;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q < CW'(Depth)) || pop_ok);
    assign used    = {1'b0, count_q} + {1'b0, rsv_i};

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Head word is kept after the last pop so the consumer sees a stable value when empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (pop_ok) begin
            hold_q <= mem_q[rd_ptr_q];
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;
    assign free_o  = (used < (CW + 1)'(Depth));

endmodule

// File: rtl/snd_dma_seq.sv
// STE DMA-sound address sequencer: frame registers with shadows, word fetcher, sample FIFO.
module snd_dma_seq
    import snd_dma_pkg::*;
#(
    parameter int unsigned AW    = 23,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk32,
    input  logic          rst,
    input  logic          reg_we,
    input  logic [1:0]    reg_sel,
    input  logic [AW-1:0] reg_din,
    output logic          req,
    output logic [AW-1:0] addr,
    input  logic          ack,
    input  logic [15:0]   din,
    input  logic          smp_rd,
    output logic [15:0]   smp_dout,
    output logic          smp_valid,
    output logic [AW-1:0] cnt_out,
    output logic          play,
    output logic          frame_end
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, start_q, start_d, end_q, end_d;
    logic [AW-1:0] start_sh_q, start_sh_d, end_sh_q, end_sh_d;
    logic [AW-1:0] addr_q, addr_d, cnt_inc;
    logic          play_q, play_d, loop_q, loop_d, req_q, req_d, fe_q, fe_d;
    logic          push, flush, fifo_free;
    logic [CW-1:0] fifo_count;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        end_d      = end_q;
        start_sh_d = start_sh_q;
        end_sh_d   = end_sh_q;
        addr_d     = addr_q;
        play_d     = play_q;
        loop_d     = loop_q;
        req_d      = req_q;
        fe_d       = 1'b0;
        push       = 1'b0;

        case (state_q)
            StIdle: begin
                if (play_q) state_d = StLoad;
            end
            StLoad: begin
                start_sh_d = start_q;
                end_sh_d   = end_q;
                cnt_d      = start_q;
                if (end_q <= start_q) begin
                    fe_d    = 1'b1;
                    play_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!play_q) begin
                    state_d = StIdle;
                end else if (fifo_free) begin
                    req_d   = 1'b1;
                    addr_d  = cnt_q;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A cleared play bit never aborts the bus cycle; it only decides where we go after.
                if (ack) begin
                    push  = 1'b1;
                    cnt_d = cnt_inc;
                    req_d = 1'b0;
                    if (cnt_inc == end_sh_q) begin
                        fe_d = 1'b1;
                        if (loop_q && play_q) begin
                            state_d = StLoad;
                        end else begin
                            play_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = play_q ? StFetch : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Firmware writes land after the FSM so a same-cycle ctrl write wins.
        if (reg_we) begin
            case (reg_sel)
                SEL_CTRL: begin
                    play_d = reg_din[0];
                    loop_d = reg_din[1];
                end
                SEL_START: start_d = reg_din;
                SEL_END:   end_d   = reg_din;
                default: ;
            endcase
        end
    end

    assign flush = (state_d == StIdle) && (state_q != StIdle);

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            start_sh_q <= '0;
            end_sh_q   <= '0;
            addr_q     <= '0;
            play_q     <= 1'b0;
            loop_q     <= 1'b0;
            req_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            end_q      <= end_d;
            start_sh_q <= start_sh_d;
            end_sh_q   <= end_sh_d;
            addr_q     <= addr_d;
            play_q     <= play_d;
            loop_q     <= loop_d;
            req_q      <= req_d;
            fe_q       <= fe_d;
        end
    end

    snd_fifo #(
        .Depth(DEPTH)
    ) u_fifo (
        .clk_i   (clk32),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (din),
        .pop_i   (smp_rd),
        .rsv_i   ({{(CW - 1){1'b0}}, req_q}),
        .data_o  (smp_dout),
        .valid_o (smp_valid),
        .count_o (fifo_count),
        .free_o  (fifo_free)
    );

    assign req       = req_q;
    assign addr      = addr_q;
    assign cnt_out   = cnt_q;
    assign play      = play_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_snd_dma_seq.sv
// Directed bench for snd_dma_seq with address/data scoreboards.
module tb_snd_dma_seq;

    localparam int unsigned AW = 23;
    localparam int unsigned DEPTH = 4;

    logic          clk32 = 1'b0;
    logic          rst = 1'b1;
    logic          reg_we = 1'b0;
    logic [1:0]    reg_sel = 2'd0;
    logic [AW-1:0] reg_din = '0;
    logic          req;
    logic [AW-1:0] addr;
    logic          ack = 1'b0;
    logic [15:0]   din = '0;
    logic          smp_rd = 1'b0;
    logic [15:0]   smp_dout;
    logic          smp_valid;
    logic [AW-1:0] cnt_out;
    logic          play;
    logic          frame_end;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    snd_dma_seq #(
        .AW(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk32     (clk32),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_din   (reg_din),
        .req       (req),
        .addr      (addr),
        .ack       (ack),
        .din       (din),
        .smp_rd    (smp_rd),
        .smp_dout  (smp_dout),
        .smp_valid (smp_valid),
        .cnt_out   (cnt_out),
        .play      (play),
        .frame_end (frame_end)
    );

    always #5 clk32 = ~clk32;

    always @(posedge clk32) if (frame_end) fe_cnt <= fe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        reg_we = 1'b1;
        reg_sel = sel;
        reg_din = data[AW-1:0];
        tick(1);
        reg_we = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        logic [31:0] ea;
        for (int i = 0; i < 40 && !req; i++) tick(1);
        check({tag, "_req_seen"}, {31'd0, req}, 32'd1);
        ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hdead_beef;
        check({tag, "_addr"}, {9'd0, addr}, ea);
    endtask

    task automatic serve(input string tag, input int hold, input logic [15:0] data,
                         input bit keep);
        logic [31:0] a0;
        wait_req(tag);
        a0 = {9'd0, addr};
        for (int i = 0; i < hold; i++) begin
            tick(1);
            check({tag, "_req_held"}, {31'd0, req}, 32'd1);
            check({tag, "_addr_stable"}, {9'd0, addr}, a0);
        end
        ack = 1'b1;
        din = data;
        if (keep) exp_data.push_back({16'd0, data});
        tick(1);
        ack = 1'b0;
        check({tag, "_req_drop"}, {31'd0, req}, 32'd0);
    endtask

    initial begin
        int fe0;
        int req_seen;

        // Reset state
        tick(2);
        rst = 1'b0;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_addr", {9'd0, addr}, 32'd0);
        check("rst_cnt", {9'd0, cnt_out}, 32'd0);
        check("rst_play", {31'd0, play}, 32'd0);
        check("rst_valid", {31'd0, smp_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_end}, 32'd0);

        // Single frame, immediate ack, consumer always popping
        fe0 = fe_cnt;
        smp_rd = 1'b1;
        wr(SEL_START_C(), 32'h100);
        wr(2'd2, 32'h104);
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + i);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 4; i++) serve("single", 0, 16'h1000 + 16'(i), 1'b0);
        check("single_fe_pulse", {31'd0, frame_end}, 32'd1);
        check("single_play", {31'd0, play}, 32'd0);
        check("single_cnt", {9'd0, cnt_out}, 32'h104);
        tick(4);
        check("single_fe_count", fe_cnt - fe0, 32'd1);
        check("single_idle", {31'd0, req}, 32'd0);

        // Looping frame with shadowed frame change
        fe0 = fe_cnt;
        wr(2'd1, 32'h200);
        wr(2'd2, 32'h202);
        exp_addr.push_back(32'h200);
        exp_addr.push_back(32'h201);
        for (int i = 0; i < 3; i++) exp_addr.push_back(32'h300);
        wr(2'd0, 32'h3);
        serve("loop0", 0, 16'h2000, 1'b0);
        wr(2'd1, 32'h300);
        wr(2'd2, 32'h301);
        serve("loop1", 0, 16'h2001, 1'b0);
        for (int i = 0; i < 3; i++) serve("loop2", 0, 16'h2002, 1'b0);
        check("loop_play", {31'd0, play}, 32'd1);
        wr(2'd0, 32'h0);
        tick(3);
        check("loop_fe_count", fe_cnt - fe0, 32'd4);

        // Backpressure: no consumer, FIFO fills after DEPTH acks
        smp_rd = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wr(2'd2, 32'h10);
        for (int i = 0; i < 4; i++) exp_addr.push_back(i);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 4; i++) serve("bp", 0, 16'hA000 + 16'(i), 1'b1);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (req) req_seen++;
            tick(1);
        end
        check("bp_no_req_full", req_seen, 32'd0);
        check("bp_valid", {31'd0, smp_valid}, 32'd1);
        check("bp_head0", {16'd0, smp_dout}, exp_data.pop_front());
        smp_rd = 1'b1;
        tick(1);
        smp_rd = 1'b0;
        exp_addr.push_back(32'h4);
        serve("bp_one", 0, 16'hA004, 1'b1);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (req) req_seen++;
            tick(1);
        end
        check("bp_no_req_again", req_seen, 32'd0);
        smp_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_order", {16'd0, smp_dout}, exp_data.pop_front());
            tick(1);
        end
        smp_rd = 1'b0;

        // Stop mid-fetch: the freed slot has a request in flight at 0x005
        exp_addr.push_back(32'h5);
        check("stop_req_pending", {31'd0, req}, 32'd1);
        wr(2'd0, 32'h0);
        serve("stop", 5, 16'hB005, 1'b0);
        tick(1);
        check("stop_play", {31'd0, play}, 32'd0);
        check("stop_flushed", {31'd0, smp_valid}, 32'd0);
        check("stop_idle", {31'd0, req}, 32'd0);

        // Degenerate frame
        fe0 = fe_cnt;
        wr(2'd1, 32'h50);
        wr(2'd2, 32'h50);
        wr(2'd0, 32'h3);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (req) req_seen++;
            tick(1);
        end
        check("degen_no_req", req_seen, 32'd0);
        check("degen_fe_count", fe_cnt - fe0, 32'd1);
        check("degen_play", {31'd0, play}, 32'd0);

        // Reset while waiting, with an ack in the same cycle
        wr(2'd1, 32'h600);
        wr(2'd2, 32'h700);
        exp_addr.push_back(32'h600);
        exp_addr.push_back(32'h601);
        wr(2'd0, 32'h1);
        serve("rstw0", 0, 16'hC000, 1'b1);
        wait_req("rstw1");
        rst = 1'b1;
        ack = 1'b1;
        din = 16'hBEEF;
        tick(1);
        rst = 1'b0;
        ack = 1'b0;
        exp_data.delete();
        check("rstw_req", {31'd0, req}, 32'd0);
        check("rstw_cnt", {9'd0, cnt_out}, 32'd0);
        check("rstw_valid", {31'd0, smp_valid}, 32'd0);
        check("rstw_play", {31'd0, play}, 32'd0);
        check("rstw_fe", {31'd0, frame_end}, 32'd0);
        ack = 1'b1;
        din = 16'h1234;
        tick(1);
        ack = 1'b0;
        tick(1);
        check("late_ack_valid", {31'd0, smp_valid}, 32'd0);
        check("late_ack_req", {31'd0, req}, 32'd0);
        check("addr_queue_empty", exp_addr.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [1:0] SEL_START_C();
        return 2'd1;
    endfunction

endmodule
